// File: rtl/clk_sched.sv
// clk_sched: programmable tick / derived-clock scheduler.
// A run divides clk by a latched period, issuing a one-cycle tick per period,
// toggling gen_clk on every tick and counting ticks until run_len is reached
// (or forever when run_len is 0). All outputs come straight from registers.
module clk_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] run_len,
  output logic             tick,
  output logic             gen_clk,
  output logic [CNT_W-1:0] tick_cnt,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;     // divider counter, 0 .. per_q-1
  logic [CNT_W-1:0] per_q, per_d;     // latched period, never 0
  logic [CNT_W-1:0] len_q, len_d;     // latched run length, 0 = endless
  logic [CNT_W-1:0] cnt_d;
  logic             tick_d, gen_d, busy_d, done_d;

  logic             wrap;
  logic             last_tick;
  logic [CNT_W-1:0] cnt_inc;

  // Divider wraps when it has counted a full period; the run ends when the
  // tick about to be issued is the run_len-th one.
  assign wrap      = (div_q == per_q - ONE);
  assign cnt_inc   = tick_cnt + ONE;
  assign last_tick = (len_q != '0) && (cnt_inc == len_q);

  // Next-state and next-output logic for the IDLE/RUN/DONE controller.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    div_d   = div_q;
    per_d   = per_q;
    len_d   = len_q;
    cnt_d   = tick_cnt;
    gen_d   = gen_clk;
    tick_d  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        // stop has no meaning outside a run; start (even with stop) begins one
        if (start) begin
          state_d = RUN;
          per_d   = (period == '0) ? ONE : period;
          len_d   = run_len;
          div_d   = '0;
          cnt_d   = '0;
          gen_d   = 1'b0;
        end
      end

      RUN: begin
        // start is ignored so the latched configuration holds for the run
        if (stop) begin
          // stop beats a coincident wrap: no tick, no count
          state_d = IDLE;
        end else if (wrap) begin
          div_d  = '0;
          tick_d = 1'b1;
          gen_d  = ~gen_clk;
          cnt_d  = cnt_inc;
          if (last_tick) state_d = DONE;
        end else begin
          div_d = div_q + ONE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and output registers; synchronous reset overrides start and stop.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge
    // values computed above, independent of statement order.
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      per_q    <= ONE;
      len_q    <= '0;
      tick     <= 1'b0;
      gen_clk  <= 1'b0;
      tick_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      per_q    <= per_d;
      len_q    <= len_d;
      tick     <= tick_d;
      gen_clk  <= gen_d;
      tick_cnt <= cnt_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_clk_sched.sv
// tb_clk_sched: directed bench for clk_sched. Expected values are computed
// from edge numbers relative to the start edge (tick on every multiple of P).
module tb_clk_sched;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [15:0] period, run_len;
  logic        tick, gen_clk, busy, done;
  logic [15:0] tick_cnt;

  logic        start4, stop4;
  logic [3:0]  period4, run_len4;
  logic        tick4, gen_clk4, busy4, done4;
  logic [3:0]  tick_cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  clk_sched #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .period(period), .run_len(run_len),
    .tick(tick), .gen_clk(gen_clk), .tick_cnt(tick_cnt),
    .busy(busy), .done(done)
  );

  clk_sched #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .stop(stop4),
    .period(period4), .run_len(run_len4),
    .tick(tick4), .gen_clk(gen_clk4), .tick_cnt(tick_cnt4),
    .busy(busy4), .done(done4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check all outputs for edges first..last after the start edge.
  task automatic run_check(input int p, input int len, input int first, input int last);
    for (int e = first; e <= last; e++) begin
      int nt;
      step();
      nt = e / p;
      check($sformatf("p%0d tick@%0d", p, e), tick, ((e % p) == 0) ? 1 : 0);
      check($sformatf("p%0d cnt@%0d", p, e), tick_cnt, nt);
      check($sformatf("p%0d gen@%0d", p, e), gen_clk, nt % 2);
      check($sformatf("p%0d done@%0d", p, e), done, (len != 0 && nt >= len) ? 1 : 0);
      check($sformatf("p%0d busy@%0d", p, e), busy, (len != 0 && nt >= len) ? 0 : 1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " tick"}, tick, 0);
    check({tag, " gen"}, gen_clk, 0);
    check({tag, " cnt"}, tick_cnt, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b1; stop = 1'b0; period = 16'd5; run_len = 16'd4;
    start4 = 1'b0; stop4 = 1'b0; period4 = 4'd2; run_len4 = 4'd0;

    // Reset, with start held to show reset priority
    step(); step();
    check_reset_vals("reset");
    check("reset dut4 cnt", tick_cnt4, 0);
    check("reset dut4 busy", busy4, 0);
    rst = 1'b0;

    // period=5, run_len=4: ticks at k+5/10/15/20, done from k+20
    step();                       // start sampled: edge k
    start = 1'b0;
    check("p5 busy@0", busy, 1);
    check("p5 cnt@0", tick_cnt, 0);
    run_check(5, 4, 1, 20);
    step(); step();
    check("p5 hold tick", tick, 0);
    check("p5 hold cnt", tick_cnt, 4);
    check("p5 hold gen", gen_clk, 0);
    check("p5 hold done", done, 1);
    check("p5 hold busy", busy, 0);

    // period=0 (treated as 1), run_len=3, started from DONE
    period = 16'd0; run_len = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    check("p1 cnt@0", tick_cnt, 0);
    check("p1 done@0", done, 0);
    check("p1 gen@0", gen_clk, 0);
    run_check(1, 3, 1, 3);
    step();
    check("p1 tick after done", tick, 0);
    check("p1 done hold", done, 1);
    check("p1 gen hold", gen_clk, 1);

    // period=4, run_len=0, stop at k+8 coinciding with second wrap
    period = 16'd4; run_len = 16'd0; start = 1'b1;
    step();
    start = 1'b0;
    run_check(4, 0, 1, 7);
    stop = 1'b1;
    step();                       // edge k+8
    check("stop tick", tick, 0);
    check("stop cnt", tick_cnt, 1);
    check("stop busy", busy, 0);
    check("stop done", done, 0);
    check("stop gen", gen_clk, 1);
    step();                       // stop in IDLE is ignored
    stop = 1'b0;
    check("idle tick", tick, 0);
    check("idle cnt", tick_cnt, 1);
    check("idle gen", gen_clk, 1);

    // start+stop together in IDLE resolves as start; rst at k+7 of period 3
    period = 16'd3; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("start+stop busy", busy, 1);
    check("start+stop cnt", tick_cnt, 0);
    run_check(3, 0, 1, 6);
    rst = 1'b1;
    step();                       // edge k+7
    rst = 1'b0;
    check_reset_vals("midrun rst");
    for (int e = 8; e <= 10; e++) begin
      step();
      check($sformatf("post rst tick@%0d", e), tick, 0);
      check($sformatf("post rst busy@%0d", e), busy, 0);
    end

    // start during RUN is ignored; start from DONE takes the new config
    period = 16'd3; run_len = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    run_check(3, 3, 1, 1);
    start = 1'b1; period = 16'd7; run_len = 16'd9;
    run_check(3, 3, 2, 2);
    start = 1'b0;
    run_check(3, 3, 3, 9);
    step();
    check("ign done hold", done, 1);
    check("ign cnt hold", tick_cnt, 3);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart cnt", tick_cnt, 0);
    check("restart busy", busy, 1);
    check("restart done", done, 0);
    run_check(7, 9, 1, 7);

    // CNT_W=4, period=2, run_len=0: tick_cnt wraps 15 -> 0, busy stays 1
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (e == 30) check("w4 cnt@30", tick_cnt4, 15);
      if (e == 32) check("w4 cnt@32", tick_cnt4, 0);
      if (e == 32) check("w4 busy@32", busy4, 1);
      if (e == 40) begin
        check("w4 cnt@40", tick_cnt4, 4);
        check("w4 busy@40", busy4, 1);
        check("w4 done@40", done4, 0);
        check("w4 tick@40", tick4, 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_sched.md
CLK_SCHED -- requirements
Module: clk_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the period, run-length and tick-count fields.
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port rst, input, 1, a synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 SHALL have port start, input, 1, a request to latch the configuration and begin a run.
REQ-005 SHALL have port stop, input, 1, a request to abort the current run.
REQ-006 SHALL have port period, input, CNT_W, the number of clk cycles per tick; 0 is treated as 1.
REQ-007 SHALL have port run_len, input, CNT_W, the number of ticks in a run; 0 means run until stop.
REQ-008 SHALL have port tick, output, 1, a one-cycle enable pulse issued once per period.
REQ-009 SHALL have port gen_clk, output, 1, a derived clock that toggles on every tick.
REQ-010 SHALL have port tick_cnt, output, CNT_W, the number of ticks issued in the current run.
REQ-011 SHALL have port busy, output, 1, high while the block is in state RUN.
REQ-012 SHALL have port done, output, 1, high while the block is in state DONE.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, RUN and DONE, and all outputs registered.
REQ-014 SHALL, when start is sampled high in IDLE or DONE:
- latch period (0 stored as 1) and run_len;
- clear the divider counter, tick_cnt and gen_clk;
- enter RUN on the same edge.
REQ-015 SHALL ignore start while in RUN; latched values SHALL NOT change mid-run.
REQ-016 SHALL, in RUN, increment the divider counter each cycle, wrapping to 0 after reaching period-1.
REQ-017 SHALL, on each wrap, drive tick high for exactly one cycle, toggle gen_clk and increment tick_cnt, all on the same edge.
REQ-018 SHALL place the first tick on edge k+P after a start sampled at edge k, with a tick spacing of exactly P cycles (P = latched period); with P=1, tick SHALL stay high continuously in RUN.
REQ-019 SHALL, when run_len≠0 and the increment makes tick_cnt equal run_len, enter DONE on that same edge; the final tick pulse is still issued.
REQ-020 SHALL, in DONE, hold tick low and hold gen_clk, tick_cnt and done stable until start or rst.
REQ-021 SHALL, when run_len=0, let tick_cnt wrap modulo 2^CNT_W without leaving RUN.
REQ-022 SHALL, when stop is sampled high in RUN, enter IDLE on that edge with tick low; stop wins over a simultaneous wrap, so no tick is issued and tick_cnt is not incremented.
REQ-023 SHALL ignore stop in IDLE and DONE; start and stop sampled together in IDLE or DONE SHALL be resolved as start.
REQ-024 SHALL, in IDLE, hold tick low and keep the last tick_cnt and gen_clk values.

Reset
REQ-025 SHALL, on rst, enter IDLE with tick=0, gen_clk=0, tick_cnt=0, busy=0, done=0, the divider counter at 0 and the latched period/run_len at 1/0.
REQ-026 SHALL give rst priority over start and stop, and SHALL abort any run mid-operation with no further tick.

Verification
REQ-027 SHALL cover: period=5, run_len=4, start at edge k -> ticks at edges k+5/10/15/20; gen_clk period 10 cycles; done=1 and tick_cnt=4 from edge k+20; busy=0 after.
REQ-028 SHALL cover: period=0, run_len=3 -> tick high for edges k+1..k+3; done at k+3.
REQ-029 SHALL cover: period=4, run_len=0, stop at edge k+8 (coincides with the second wrap) -> exactly 1 tick; tick_cnt=1; IDLE; done=0.
REQ-030 SHALL cover: period=2, run_len=0, CNT_W=4, run for 40 cycles -> tick_cnt wraps 15->0; busy stays 1.
REQ-031 SHALL cover: rst at edge k+7 of a period=3 run -> all outputs at reset values on the next cycle; no tick at k+9.
REQ-032 SHALL cover: start while in RUN with new period -> ignored, spacing unchanged; start while in DONE -> new run with new config, tick_cnt cleared.
